// File: rtl/dsp_seq_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

  // X=M, Z=0 starts a fresh sum; X=M, Z=P accumulates onto P.
  localparam logic [7:0] OPMODE_IDLE      = 8'h00;
  localparam logic [7:0] OPMODE_MUL_FIRST = 8'h01;
  localparam logic [7:0] OPMODE_MUL_ACC   = 8'h09;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic v;
    logic first;
  } tag_t;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Command, operand stream and DSP slice signals of the MAC sequencer.
interface dsp_mac_sequencer_if #(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a_in;
  logic [B_W-1:0]   b_in;
  logic [A_W-1:0]   dsp_a;
  logic [B_W-1:0]   dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cea;
  logic             dsp_ceb;
  logic             dsp_cem;
  logic             dsp_cep;
  logic             dsp_rstp;
  logic [P_W-1:0]   p_in;
  logic [P_W-1:0]   result;
  logic             result_valid;

  modport master (
    output start, len, in_valid, a_in, b_in, p_in,
    input  busy, in_ready, dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb,
           dsp_cem, dsp_cep, dsp_rstp, result, result_valid
  );

  modport slave (
    input  start, len, in_valid, a_in, b_in, p_in,
    output busy, in_ready, dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb,
           dsp_cem, dsp_cep, dsp_rstp, result, result_valid
  );
endinterface

// File: rtl/mac_tag_pipe.sv
// Tag shift register that tracks each accepted term until its P update.
module mac_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST,
  input  tag_t tag_d,
  output tag_t tag_q,
  output logic upstream_v
);

  tag_t stg [DEPTH];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= tag_d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign tag_q = stg[DEPTH-1];

  // Any term still in flight ahead of the stage currently driving CEP.
  always_comb begin
    upstream_v = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) upstream_v = upstream_v | stg[i].v;
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1-style slice through an N-term multiply-accumulate.
//   state | meaning
//   IDLE  | waiting for start
//   CLR   | len==0: pulse RSTP so the result reads as zero
//   FEED  | accepting operand pairs while terms remain
//   DRAIN | all terms accepted, waiting for the last P update
//   DONE  | P is stable, present result for one cycle
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int P_W      = 48,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input logic           CLK,
  input logic           RST,
  dsp_mac_sequencer_if.slave bus
);

  localparam int TAG_DEPTH = PIPE_LAT - 1;

  generate
    if (PIPE_LAT < 2 || PIPE_LAT > 4) begin : g_bad_lat
      $error("dsp_mac_sequencer: PIPE_LAT must be in 2..4");
    end
  endgenerate

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic             accept;
  logic             ce_pipe;
  logic             ready;
  logic             clr_pulse;
  logic             done;
  tag_t             tag_in, tag_out;
  logic             upstream_v;
  logic [7:0]       opmode;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    first_d   = first_q;
    accept    = 1'b0;
    ce_pipe   = 1'b0;
    ready     = 1'b0;
    clr_pulse = 1'b0;
    done      = 1'b0;
    tag_in    = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d = FEED;
            rem_d   = bus.len;
            first_d = 1'b1;
          end else begin
            state_d = CLR;
          end
        end
      end
      CLR: begin
        clr_pulse = 1'b1;
        state_d   = DONE;
      end
      FEED: begin
        ce_pipe      = 1'b1;
        ready        = (rem_q != '0);
        accept       = bus.in_valid & ready;
        tag_in.v     = accept;
        tag_in.first = accept & first_q;
        if (accept) begin
          rem_d   = rem_q - LEN_W'(1);
          first_d = 1'b0;
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        ce_pipe = 1'b1;
        // The final stage issues its CEP this cycle, so P settles at the edge.
        if (!upstream_v) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mac_tag_pipe #(.DEPTH(TAG_DEPTH)) u_tag_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .tag_d     (tag_in),
    .tag_q     (tag_out),
    .upstream_v(upstream_v)
  );

  always_comb begin
    opmode = OPMODE_IDLE;
    if (tag_out.v) opmode = tag_out.first ? OPMODE_MUL_FIRST : OPMODE_MUL_ACC;
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.in_ready     = ready;
  assign bus.dsp_a        = A_W'(bus.a_in);
  assign bus.dsp_b        = B_W'(bus.b_in);
  assign bus.dsp_cea      = ce_pipe;
  assign bus.dsp_ceb      = ce_pipe;
  assign bus.dsp_cem      = ce_pipe;
  assign bus.dsp_cep      = tag_out.v;
  assign bus.dsp_opmode   = opmode;
  assign bus.dsp_rstp     = ~RST | clr_pulse;
  assign bus.result       = done ? bus.p_in : {P_W{1'b0}};
  assign bus.result_valid = done;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed and randomized bench for dsp_mac_sequencer with a behavioural DSP slice.
module tb_dsp_mac_sequencer;
  import dsp_seq_pkg::*;

  localparam int A_W = 18, B_W = 18, P_W = 48, LEN_W = 8, PIPE_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsp_mac_sequencer_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W)) bus ();

  dsp_mac_sequencer #(
    .A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)
  ) u_dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Behavioural slice: A/B regs, M reg, P reg with X/Z OPMODE selects.
  logic signed [A_W-1:0]     a_r;
  logic signed [B_W-1:0]     b_r;
  logic signed [A_W+B_W-1:0] m_r;
  logic [P_W-1:0]            p_r;
  always @(posedge clk) begin
    if (bus.dsp_cea) a_r <= bus.dsp_a;
    if (bus.dsp_ceb) b_r <= bus.dsp_b;
    if (bus.dsp_cem) m_r <= a_r * b_r;
    if (bus.dsp_rstp) p_r <= '0;
    else if (bus.dsp_cep)
      p_r <= ((bus.dsp_opmode[3:2] == 2'b10) ? p_r : {P_W{1'b0}}) +
             ((bus.dsp_opmode[1:0] == 2'b01) ? {{(P_W-A_W-B_W){m_r[A_W+B_W-1]}}, m_r} : {P_W{1'b0}});
  end
  assign bus.p_in = p_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int             rv_cnt = 0, cep_cnt = 0, ready_cnt = 0, rstp_cnt = 0;
  int             last_acc = 0, rv_cyc = 0, start_cyc = 0;
  logic [P_W-1:0] rv_res = '0;
  int             cep_cyc[$];
  logic [7:0]     ops[$];

  always @(negedge clk) begin
    #3;
    if (bus.result_valid) begin
      rv_cnt++;
      rv_res = bus.result;
      rv_cyc = cyc;
    end
    if (bus.in_valid && bus.in_ready) last_acc = cyc;
    if (bus.in_ready) ready_cnt++;
    if (bus.dsp_cep) begin
      cep_cnt++;
      cep_cyc.push_back(cyc);
      ops.push_back(bus.dsp_opmode);
    end
    if (bus.dsp_rstp && rst) rstp_cnt++;
    if (bus.start && !bus.busy) start_cyc = cyc;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic signed [A_W-1:0] qa[$];
  logic signed [B_W-1:0] qb[$];
  int b_rdy, b_q;

  task automatic add(input int a, input int b);
    qa.push_back(A_W'(a));
    qb.push_back(B_W'(b));
  endtask

  // Runs one command from the current negedge; expected sum comes from plain arithmetic.
  task automatic run_seq(input string tag, input int n, input int gap_at, input int gap_len,
                         input bit rnd_bub, input bit poke);
    longint         acc = 0;
    logic [P_W-1:0] exp_res;
    int b_rv, b_cep, b_rstp, idx, g, guard, nacc;
    foreach (qa[i]) acc += longint'(qa[i]) * longint'(qb[i]);
    exp_res = acc[P_W-1:0];
    b_rv = rv_cnt; b_cep = cep_cnt; b_rstp = rstp_cnt; b_rdy = ready_cnt; b_q = cep_cyc.size();
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    idx = 0; g = 0; guard = 0;
    while (idx < n && guard < 400) begin
      bus.start = poke && (idx == 1);
      bus.len   = LEN_W'($urandom_range(1, 200));
      if ((idx == gap_at && g < gap_len) || (rnd_bub && $urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        bus.a_in     = A_W'($urandom);
        bus.b_in     = B_W'($urandom);
        if (idx == gap_at) g++;
      end else begin
        bus.in_valid = 1'b1;
        bus.a_in     = qa[idx];
        bus.b_in     = qb[idx];
      end
      #1;
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = poke;
    check({tag, ":fed"}, 64'(idx), 64'(n));
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (rv_cnt == b_rv && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check({tag, ":rv_cnt"}, 64'(rv_cnt - b_rv), 64'd1);
    check({tag, ":result"}, 64'(rv_res), 64'(exp_res));
    check({tag, ":cep_cnt"}, 64'(cep_cnt - b_cep), 64'(n));
    if (n > 0) begin
      check({tag, ":latency"}, 64'(rv_cyc - last_acc), 64'(PIPE_LAT));
      check({tag, ":op_first"}, 64'(ops[b_q]), 64'(OPMODE_MUL_FIRST));
      nacc = 0;
      for (int i = b_q + 1; i < ops.size(); i++) if (ops[i] !== OPMODE_MUL_ACC) nacc++;
      check({tag, ":op_acc"}, 64'(nacc), 64'd0);
    end else begin
      check({tag, ":clr_lat"}, 64'(rv_cyc - start_cyc), 64'd2);
      check({tag, ":rstp_cnt"}, 64'(rstp_cnt - b_rstp), 64'd1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, b_rv;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst:busy", 64'(bus.busy), 64'd0);
    check("rst:in_ready", 64'(bus.in_ready), 64'd0);
    check("rst:result_valid", 64'(bus.result_valid), 64'd0);
    check("rst:ce", 64'({bus.dsp_cea, bus.dsp_ceb, bus.dsp_cem, bus.dsp_cep}), 64'd0);
    check("rst:opmode", 64'(bus.dsp_opmode), 64'd0);
    check("rst:rstp", 64'(bus.dsp_rstp), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("idle:rstp", 64'(bus.dsp_rstp), 64'd0);

    // Back-to-back four terms, sum 100.
    qa.delete(); qb.delete();
    add(3, 5); add(-2, 7); add(10, 10); add(1, -1);
    run_seq("b2b4", 4, -1, 0, 1'b0, 1'b0);
    check("b2b4:ready_cyc", 64'(ready_cnt - b_rdy), 64'd4);
    check("b2b4:cep_run", 64'(cep_cyc[b_q+3] - cep_cyc[b_q]), 64'd3);

    // Two-cycle bubble between the first and second terms, sum 29.
    qa.delete(); qb.delete();
    add(2, 2); add(3, 3); add(4, 4);
    run_seq("bubble", 3, 1, 2, 1'b0, 1'b0);
    check("bubble:cep_gap", 64'(cep_cyc[b_q+1] - cep_cyc[b_q]), 64'd3);

    qa.delete(); qb.delete();
    run_seq("len0", 0, -1, 0, 1'b0, 1'b0);

    qa.delete(); qb.delete();
    add(131071, 131071); add(131071, 131071);
    run_seq("maxpos", 2, -1, 0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    add(-131072, 131071); add(-131072, 131071);
    run_seq("maxneg", 2, -1, 0, 1'b0, 1'b0);

    // Reset after two of five terms abandons the sequence.
    b_rv = rv_cnt;
    bus.start = 1'b1; bus.len = LEN_W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.a_in = A_W'(9); bus.b_in = B_W'(9);
    @(negedge clk);
    bus.a_in = A_W'(8); bus.b_in = B_W'(8);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst:busy", 64'(bus.busy), 64'd0);
    check("midrst:in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst:cep", 64'(bus.dsp_cep), 64'd0);
    check("midrst:rstp", 64'(bus.dsp_rstp), 64'd1);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst:no_rv", 64'(rv_cnt - b_rv), 64'd0);
    check("midrst:p_clear", 64'(bus.p_in), 64'd0);
    qa.delete(); qb.delete();
    add(6, 7);
    run_seq("after_rst", 1, -1, 0, 1'b0, 1'b0);

    // Start poked during FEED and DRAIN, then an immediate second sequence.
    qa.delete(); qb.delete();
    add(-5, 11); add(7, -3); add(100, 200); add(-1, -1); add(12, 12);
    run_seq("poke", 5, -1, 0, 1'b0, 1'b1);
    qa.delete(); qb.delete();
    add(4, 4); add(-9, 2);
    run_seq("b2b_next", 2, -1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      qa.delete(); qb.delete();
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        qa.push_back(A_W'($urandom));
        qb.push_back(B_W'($urandom));
      end
      run_seq($sformatf("rand%0d", r), n, -1, 0, 1'b1, r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP48A1-style slice (A/B input regs, M reg, P reg, each with its own clock enable) through an N-term multiply-accumulate (dot product).
- Accepts a start command with a term count, then takes operand pairs over a valid/ready stream.
- Drives the slice's A/B data, OPMODE, CE and RSTP lines, and returns the final P value with a one-cycle valid.
- Sits between the ALSU command path and the DSP slice wrapper.

Parameters:
A_W, 18, width of operand A / slice A port
B_W, 18, width of operand B / slice B port
P_W, 48, width of slice P port and result
LEN_W, 8, width of the term-count field
PIPE_LAT, 3, edges from operand capture to P update; legal range 2..4, elaborate-time error otherwise

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-low
start  in  1  command strobe, sampled only in IDLE
len  in  LEN_W  number of terms, sampled with start
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  high in FEED while terms remain
a_in  in  A_W  operand A
b_in  in  B_W  operand B
dsp_a  out  A_W  to slice A, combinational copy of a_in
dsp_b  out  B_W  to slice B, combinational copy of b_in
dsp_opmode  out  8  to slice OPMODE
dsp_cea  out  1  A register enable
dsp_ceb  out  1  B register enable
dsp_cem  out  1  M register enable
dsp_cep  out  1  P register enable
dsp_rstp  out  1  P register reset, active-high
p_in  in  P_W  from slice P
result  out  P_W  final accumulation
result_valid  out  1  one-cycle pulse, result valid

Behaviour:
- Reset (RST=0 at an edge):
  - State goes to IDLE; remaining-count and tag pipeline are cleared.
  - busy=0, in_ready=0, result_valid=0, cea/ceb/cem/cep=0, opmode=8'h00.
  - dsp_rstp = ~RST | clr_pulse, so the slice P register clears during reset.
  - Reset mid-operation abandons the sequence; no result_valid is produced.
- States:
  - IDLE: on start, with len>0 go to FEED and load remaining=len; with len==0 go to CLR.
  - CLR: dsp_rstp=1 for one cycle, then go to DONE.
  - FEED:
    - cea=ceb=cem=1; in_ready=(remaining!=0).
    - Accept is in_valid&in_ready at an edge; each accept decrements remaining.
    - On the edge where remaining goes from 1 to 0, go to DRAIN.
  - DRAIN: cea=ceb=cem=1; in_ready=0. When the tag pipeline is empty and the last CEP has been issued, go to DONE.
  - DONE: result_valid=1 and result=p_in (P is stable because cep=0), for one cycle, then go to IDLE.
- Tag pipeline:
  - Shift register of PIPE_LAT-1 stages, each stage {v, first}.
  - Stage 0 loads {accept, accept & first_term_of_sequence} every FEED/DRAIN cycle; in other states it loads 0.
  - Bubbles (in_valid=0) enter as v=0; stall never halts the shift.
- Final stage output drives the P stage:
  - dsp_cep = v.
  - dsp_opmode = first ? 8'h01 (X=M, Z=0) : 8'h09 (X=M, Z=P) when v=1; 8'h00 otherwise.
- Timing: an operand accepted at edge t updates P at edge t+PIPE_LAT-1. For PIPE_LAT=3, back-to-back terms give full throughput of 1 term/cycle.
- Arithmetic: signed two's complement; accumulation wraps modulo 2^P_W with no saturation.
- start outside IDLE is ignored; a/b values during bubbles are don't-care.
- Latency from the last accept to result_valid is PIPE_LAT cycles.

Decomposition:
- Package dsp_seq_pkg holds:
  - OPMODE_MUL_FIRST=8'h01 and OPMODE_MUL_ACC=8'h09;
  - the state enum IDLE/CLR/FEED/DRAIN/DONE;
  - the tag struct {v, first}.
- Sub-module mac_tag_pipe: parameterised depth shift register with synchronous active-low clear. The FSM and count logic stay in the top module.

Test Plan:
- len=4, pairs (3,5),(−2,7),(10,10),(1,−1) back-to-back.
  - in_ready high for 4 cycles; cep high for 4 consecutive cycles; first opmode is 8'h01, then 8'h09.
  - result_valid pulses 3 cycles after the last accept, with result=100.
- len=3 with a bubble: in_valid low for 2 cycles between terms 1 and 2, pairs (2,2),(3,3),(4,4).
  - cep shows a 2-cycle gap; result=29; exactly one result_valid.
- len=0: start leads to CLR with rstp=1 for one cycle, then result_valid with result=0, 2 cycles after start.
- Wrap: P_W=48, len=2, operands (2^17−1)·(2^17−1) twice.
  - result=2·(2^17−1)^2; sign preserved with (−2^17)·(2^17−1).
- Reset mid-FEED after 2 of 5 terms (RST=0 for 1 cycle).
  - Next cycle: busy=0, in_ready=0, cep=0, rstp=1 during reset; no result_valid.
  - A new start with len=1, pair (6,7), then gives result=42.
- start pulsed again during FEED/DRAIN is ignored, and remaining is unchanged. Two back-to-back sequences return correct independent results with no carry-over (second first opmode = 8'h01).
